// File: rtl/mem_arb_pkg.sv
// Shared types for the minisoc RAM arbiter.
//   port_e    : identifies which requester owns a RAM access (or none).
//   mem_req_t : the request fields of the port selected for the RAM this cycle.
//   ram_we_mask: turns a selected request into the RAM byte write mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_DBG,
    PORT_IF,
    PORT_LS
  } port_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // A write with an empty strobe becomes a read because the mask is all zero.
  function automatic logic [3:0] ram_we_mask(mem_req_t req);
    return req.we ? req.wstrb : 4'b0000;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake and RAM signal around mem_arbiter.
//   Requester side : <port>_req/_we/_wstrb/_addr/_wdata in, <port>_gnt/_rvalid out, rdata out.
//   RAM side       : ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in.
//   slave modport  : view taken by the arbiter.
//   master modport : view taken by the requesters and the RAM (the environment).
interface mem_arbiter_if #(
  parameter int unsigned RAM_AW = 22
);

  logic              dbg_req,   if_req,   ls_req;
  logic              dbg_we,    if_we,    ls_we;
  logic [3:0]        dbg_wstrb, ls_wstrb;
  logic [31:0]       dbg_addr,  if_addr,  ls_addr;
  logic [31:0]       dbg_wdata, ls_wdata;
  logic              dbg_gnt,   if_gnt,   ls_gnt;
  logic              dbg_rvalid, if_rvalid, ls_rvalid;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-3:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  dbg_req, if_req, ls_req,
    input  dbg_we, if_we, ls_we,
    input  dbg_wstrb, ls_wstrb,
    input  dbg_addr, if_addr, ls_addr,
    input  dbg_wdata, ls_wdata,
    output dbg_gnt, if_gnt, ls_gnt,
    output dbg_rvalid, if_rvalid, ls_rvalid,
    output rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output dbg_req, if_req, ls_req,
    output dbg_we, if_we, ls_we,
    output dbg_wstrb, ls_wstrb,
    output dbg_addr, if_addr, ls_addr,
    output dbg_wdata, ls_wdata,
    input  dbg_gnt, if_gnt, ls_gnt,
    input  dbg_rvalid, if_rvalid, ls_rvalid,
    input  rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clk, rst_b : clock and asynchronous active-low reset.
//   i_block    : a higher-priority requester owns the slot; grant nobody, keep the pointer.
//   i_req[1:0] : requests, bit 0 = port A (IF), bit 1 = port B (LS).
//   o_gnt[1:0] : combinational one-hot grant, same bit order as i_req.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       i_block,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 1 = port B won the most recent contested or uncontested slot.
  logic r_last_b;

  always_comb begin
    o_gnt = 2'b00;
    if (!i_block) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last_b ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last_b <= 1'b1;
    end else if (|o_gnt) begin
      r_last_b <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the minisoc: DBG (debug loader), IF (fetch), LS (load/store).
//   clk, rst_b : clock and asynchronous active-low reset.
//   bus        : mem_arbiter_if.slave carrying all request, grant, response and RAM signals.
// DBG has fixed priority; IF and LS share the remaining slots round-robin. At most one RAM
// access per cycle; the 1-cycle RAM response is flagged on the port that issued it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_AW = 22,
  parameter bit          DBG_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_b,
  mem_arbiter_if.slave   bus
);

  logic       w_dbg_req;
  logic [1:0] w_rr_gnt;
  port_e      w_owner;
  mem_req_t   w_sel;

  logic       r_rsp_valid;
  port_e      r_rsp_owner;

  assign w_dbg_req = DBG_EN && bus.dbg_req;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_block (w_dbg_req),
    .i_req   ({bus.ls_req, bus.if_req}),
    .o_gnt   (w_rr_gnt)
  );

  // Priority select. The fetch port never writes, so its write fields are forced to zero.
  always_comb begin
    w_owner = PORT_NONE;
    w_sel   = '0;
    if (w_dbg_req) begin
      w_owner = PORT_DBG;
      w_sel   = '{we: bus.dbg_we, wstrb: bus.dbg_wstrb, addr: bus.dbg_addr,
                  wdata: bus.dbg_wdata};
    end else if (w_rr_gnt[0]) begin
      w_owner = PORT_IF;
      w_sel   = '{we: 1'b0, wstrb: 4'b0000, addr: bus.if_addr, wdata: 32'h0};
    end else if (w_rr_gnt[1]) begin
      w_owner = PORT_LS;
      w_sel   = '{we: bus.ls_we, wstrb: bus.ls_wstrb, addr: bus.ls_addr,
                  wdata: bus.ls_wdata};
    end
  end

  assign bus.dbg_gnt = (w_owner == PORT_DBG);
  assign bus.if_gnt  = (w_owner == PORT_IF);
  assign bus.ls_gnt  = (w_owner == PORT_LS);

  // w_sel is all zero when idle, so ram_we is 0 without extra gating.
  assign bus.ram_en    = (w_owner != PORT_NONE);
  assign bus.ram_we    = ram_we_mask(w_sel);
  assign bus.ram_addr  = w_sel.addr[RAM_AW-1:2];
  assign bus.ram_wdata = w_sel.wdata;

  // Address bits above the RAM and the byte offset are dropped on purpose.
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.if_we, w_sel.addr[31:RAM_AW], w_sel.addr[1:0]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= PORT_NONE;
    end else begin
      r_rsp_valid <= (w_owner != PORT_NONE);
      r_rsp_owner <= w_owner;
    end
  end

  assign bus.dbg_rvalid = r_rsp_valid && (r_rsp_owner == PORT_DBG);
  assign bus.if_rvalid  = r_rsp_valid && (r_rsp_owner == PORT_IF);
  assign bus.ls_rvalid  = r_rsp_valid && (r_rsp_owner == PORT_LS);
  assign bus.rdata      = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned RamAw = 22;

  typedef struct {
    port_e       port;
    bit          chk;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int unsigned cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  port_e m_last = PORT_LS;
  exp_t sb_q[$];

  // Backdoor preload into the RAM model.
  logic               bd_we = 1'b0;
  logic [RamAw-3:0]   bd_addr = '0;
  logic [31:0]        bd_data = '0;
  logic [31:0]        mem [0:(1<<(RamAw-2))-1];

  mem_arbiter_if #(.RAM_AW(RamAw)) bus ();

  mem_arbiter #(.RAM_AW(RamAw), .DBG_EN(1'b1)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // Read-first RAM model with 1-cycle read latency.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      if (bus.ram_we != 4'b0000) mem[bus.ram_addr] <= merge(mem[bus.ram_addr], bus.ram_wdata,
                                                            bus.ram_we);
    end
  end

  function automatic logic [2:0] onehot(port_e p);
    case (p)
      PORT_DBG: return 3'b100;
      PORT_IF:  return 3'b010;
      PORT_LS:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  // Grant model: DBG first, else round-robin between IF and LS.
  function automatic port_e predict(bit d, bit i, bit l);
    if (d) return PORT_DBG;
    if (i && l) return (m_last == PORT_LS) ? PORT_IF : PORT_LS;
    if (i) return PORT_IF;
    if (l) return PORT_LS;
    return PORT_NONE;
  endfunction

  task automatic sb_push(port_e p, bit chk, logic [31:0] d);
    exp_t e;
    e.port = p;
    e.chk  = chk;
    e.data = d;
    e.due  = cyc + 1;
    sb_q.push_back(e);
    if (p == PORT_IF || p == PORT_LS) m_last = p;
  endtask

  // Scoreboard: every cycle the rvalid vector must match the entry due now (or be all zero).
  logic [2:0]  mon_exp_v, mon_act_v;
  logic [31:0] mon_exp_d;
  bit          mon_chk;
  exp_t        mon_e;
  always @(negedge clk) begin
    mon_exp_v = 3'b000;
    mon_chk   = 1'b0;
    mon_exp_d = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e     = sb_q.pop_front();
      mon_exp_v = onehot(mon_e.port);
      mon_chk   = mon_e.chk;
      mon_exp_d = mon_e.data;
    end
    mon_act_v = {bus.dbg_rvalid, bus.if_rvalid, bus.ls_rvalid};
    n_total++;
    if (mon_act_v !== mon_exp_v)
      $display("FAIL rvalid cyc %0d: got %b want %b", cyc, mon_act_v, mon_exp_v);
    else n_pass++;
    if (mon_chk) begin
      n_total++;
      if (bus.rdata !== mon_exp_d)
        $display("FAIL rdata cyc %0d: got %h want %h", cyc, bus.rdata, mon_exp_d);
      else n_pass++;
    end
  end

  task automatic idle_inputs();
    bus.dbg_req = 0; bus.if_req = 0; bus.ls_req = 0;
    bus.dbg_we = 0;  bus.if_we = 0;  bus.ls_we = 0;
    bus.dbg_wstrb = '0; bus.ls_wstrb = '0;
    bus.dbg_addr = '0;  bus.if_addr = '0; bus.ls_addr = '0;
    bus.dbg_wdata = '0; bus.ls_wdata = '0;
  endtask

  task automatic preload(logic [RamAw-3:0] a, logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    idle_inputs();
    preload(20'h00004, 32'h1234_5678);
    preload(20'h03FFC, 32'h1122_3344);
    preload(20'h00040, 32'h0A0A_0A0A);
    preload(20'h00080, 32'h0B0B_0B0B);
    @(negedge clk);
    n_total++;
    if ({bus.dbg_gnt, bus.if_gnt, bus.ls_gnt} !== 3'b000 || bus.ram_en !== 1'b0)
      $display("FAIL reset_idle: got gnt %b en %b want 000 0",
               {bus.dbg_gnt, bus.if_gnt, bus.ls_gnt}, bus.ram_en);
    else n_pass++;
    rst_b = 1'b1;
    m_last = PORT_LS;
    @(negedge clk);
    n_total++;
    if (bus.ram_en !== 1'b0 || bus.ram_we !== 4'b0000)
      $display("FAIL idle_ram: got en %b we %b want 0 0000", bus.ram_en, bus.ram_we);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    bus.if_req = 1; bus.if_addr = 32'h0000_0010; bus.if_we = 1; // if_we must be ignored
    @(negedge clk);
    n_total++;
    if ({bus.dbg_gnt, bus.if_gnt, bus.ls_gnt} !== onehot(predict(0, 1, 0)) ||
        bus.ram_en !== 1'b1 || bus.ram_addr !== 20'h4 || bus.ram_we !== 4'b0000)
      $display("FAIL single_read_req: got gnt %b en %b addr %h we %b want 010 1 00004 0000",
               {bus.dbg_gnt, bus.if_gnt, bus.ls_gnt}, bus.ram_en, bus.ram_addr, bus.ram_we);
    else n_pass++;
    sb_push(PORT_IF, 1, 32'h1234_5678);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_total++;
    if ({bus.dbg_rvalid, bus.if_rvalid, bus.ls_rvalid} !== 3'b010 ||
        bus.rdata !== 32'h1234_5678)
      $display("FAIL single_read_rsp: got rvalid %b rdata %h want 010 12345678",
               {bus.dbg_rvalid, bus.if_rvalid, bus.ls_rvalid}, bus.rdata);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h0000_FFF0;
    bus.ls_wdata = 32'hAABB_CCDD; bus.ls_wstrb = 4'b0010;
    @(negedge clk);
    n_total++;
    if (bus.ls_gnt !== 1'b1 || bus.ram_we !== 4'b0010 || bus.ram_addr !== 20'h3FFC ||
        bus.ram_wdata !== 32'hAABB_CCDD)
      $display("FAIL byte_write: got gnt %b we %b addr %h wdata %h want 1 0010 03ffc aabbccdd",
               bus.ls_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    else n_pass++;
    sb_push(PORT_LS, 0, '0);
    @(posedge clk); #1;
    bus.ls_we = 0;
    @(negedge clk);
    n_total++;
    if (bus.ls_gnt !== 1'b1 || bus.ram_we !== 4'b0000 || bus.ram_addr !== 20'h3FFC)
      $display("FAIL byte_readback_req: got gnt %b we %b addr %h want 1 0000 03ffc",
               bus.ls_gnt, bus.ram_we, bus.ram_addr);
    else n_pass++;
    sb_push(PORT_LS, 1, 32'h1122_CC44);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    port_e want;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    m_last = PORT_LS;
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    bus.ls_req = 1; bus.ls_addr = 32'h0000_0200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      want = (i % 2 == 0) ? PORT_IF : PORT_LS;
      n_total++;
      if ({bus.dbg_gnt, bus.if_gnt, bus.ls_gnt} !== onehot(want) ||
          bus.ram_addr !== ((want == PORT_IF) ? 20'h40 : 20'h80))
        $display("FAIL contention_%0d: got gnt %b addr %h want %b",
                 i, {bus.dbg_gnt, bus.if_gnt, bus.ls_gnt}, bus.ram_addr, onehot(want));
      else n_pass++;
      sb_push(want, 1, (want == PORT_IF) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_dbg_priority();
    port_e want;
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h0000_0300;
    bus.dbg_wstrb = 4'hF; bus.dbg_wdata = 32'hCAFE_F00D;
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    bus.ls_req = 1; bus.ls_addr = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.dbg_req = 0;
      @(negedge clk);
      want = (i < 3) ? PORT_DBG : (i == 3) ? PORT_IF : PORT_LS;
      n_total++;
      if ({bus.dbg_gnt, bus.if_gnt, bus.ls_gnt} !== onehot(want) ||
          bus.ram_we !== ((want == PORT_DBG) ? 4'hF : 4'h0))
        $display("FAIL dbg_priority_%0d: got gnt %b we %b want %b",
                 i, {bus.dbg_gnt, bus.if_gnt, bus.ls_gnt}, bus.ram_we, onehot(want));
      else n_pass++;
      sb_push(want, want != PORT_DBG, (want == PORT_IF) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bus.ls_req = 1; bus.ls_addr = 32'h0040_0013;
    @(negedge clk);
    n_total++;
    if (bus.ls_gnt !== 1'b1 || bus.ram_addr !== 20'h4)
      $display("FAIL wrap_addr: got gnt %b addr %h want 1 00004", bus.ls_gnt, bus.ram_addr);
    else n_pass++;
    sb_push(PORT_LS, 1, 32'h1234_5678);
    @(posedge clk); #1;
    bus.ls_addr = 32'h0000_0300; // word written by DBG
    @(negedge clk);
    n_total++;
    if (bus.ls_gnt !== 1'b1 || bus.ram_addr !== 20'hC0)
      $display("FAIL dbg_readback_addr: got gnt %b addr %h want 1 000c0",
               bus.ls_gnt, bus.ram_addr);
    else n_pass++;
    sb_push(PORT_LS, 1, 32'hCAFE_F00D);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    port_e want;
    bus.ls_req = 1; bus.ls_addr = 32'h0000_0010;
    @(negedge clk);
    n_total++;
    if (bus.ls_gnt !== 1'b1)
      $display("FAIL midop_gnt: got %b want 1", bus.ls_gnt);
    else n_pass++;
    sb_push(PORT_LS, 1, 32'h1234_5678);
    @(posedge clk); #1;
    rst_b = 1'b0;
    idle_inputs();
    sb_q.delete(); // the pending response is dropped by reset
    #1;
    n_total++;
    if (bus.ls_rvalid !== 1'b0)
      $display("FAIL midop_rvalid_drop: got %b want 0", bus.ls_rvalid);
    else n_pass++;
    @(posedge clk); #1;
    rst_b = 1'b1;
    m_last = PORT_LS;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.dbg_rvalid, bus.if_rvalid, bus.ls_rvalid} !== 3'b000)
        $display("FAIL midop_quiet_%0d: got %b want 000",
                 i, {bus.dbg_rvalid, bus.if_rvalid, bus.ls_rvalid});
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    bus.ls_req = 1; bus.ls_addr = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      want = predict(0, 1, 1);
      n_total++;
      if ({bus.dbg_gnt, bus.if_gnt, bus.ls_gnt} !== onehot(want) ||
          want != ((i == 0) ? PORT_IF : PORT_LS))
        $display("FAIL midop_contention_%0d: got gnt %b want %b",
                 i, {bus.dbg_gnt, bus.if_gnt, bus.ls_gnt}, (i == 0) ? 3'b010 : 3'b001);
      else n_pass++;
      sb_push(want, 1, (want == PORT_IF) ? 32'h0A0A_0A0A : 32'h0B0B_0B0B);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_dbg_priority();
    test_wrap();
    test_reset_midop();
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
